received_msg_packer: RTL and testbench
======================================

Name: received_msg_packer

Overview:
- Downstream consumer of the memory manager's received-number handshake (num / replaced / valid / overrun / ack).
- Captures one received-number report, acks it, and serialises it as a framed byte message onto a byte-wide valid/ready stream feeding the UART transmitter.
- Runs one report at a time. While a message is in flight, the memory manager holds further reports in its own valid/overrun logic.

Parameters:
- ADDR_WIDTH, 8, width of the word-address field of a received-number report.
- DATA_WIDTH, 16, width of the data field of a received-number report.
- MSG_ID, 8'h05, message-type byte sent first in every frame.
- PAYLOAD_BYTES, derived as ceil((ADDR_WIDTH+DATA_WIDTH)/8), number of payload bytes; not overridable.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- n_reset  in  1  reset, synchronous, active-low.
- mem_received_num  in  ADDR_WIDTH+DATA_WIDTH  report: {addr, data}, addr in the MSBs.
- mem_received_replaced  in  1  report was a replacement number.
- mem_received_valid  in  1  report available; drops combinationally while ack is high.
- mem_received_overrun  in  1  sticky overrun flag from the memory manager.
- mem_received_ack  out  1  single-cycle registered acknowledge.
- tx_data  out  8  byte to the UART transmitter.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  transmitter accepts tx_data this cycle.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (n_reset low at a clock edge): state=IDLE, byte_ctr=0, capture registers=0, mem_received_ack=0, tx_valid=0, tx_data=0, busy=0.
- Reset mid-message discards the frame immediately. tx_valid is low the cycle after the reset edge.
- State IDLE:
  - If mem_received_valid=1, load the capture registers: num, replaced, and overrun sampled in the same cycle. Go to ACK.
  - Otherwise stay in IDLE.
- State ACK (exactly one cycle):
  - mem_received_ack=1. No other state drives ack.
  - Load byte 0 into tx_data, set tx_valid=1, byte_ctr=0. Go to SEND.
- State SEND:
  - A byte transfers on a cycle with tx_valid && tx_ready.
  - On transfer with byte_ctr < 1+PAYLOAD_BYTES: increment byte_ctr and present the next byte on the following cycle. tx_valid stays high, so back-to-back transfers run at 1 byte/cycle.
  - On transfer of the last byte (byte_ctr = 1+PAYLOAD_BYTES): tx_valid=0, go to IDLE.
  - While tx_valid && !tx_ready, tx_data and tx_valid hold stable.
- Frame format, 2+PAYLOAD_BYTES bytes:
  - byte0 = MSG_ID.
  - byte1 = {6'b0, overrun, replaced}.
  - bytes 2.. = zero-extended {addr, data}, most-significant byte first.
- Latency: mem_received_valid rising in IDLE at cycle N gives ack at N+1 and first tx_valid at N+2.
- Minimum spacing between frames: one IDLE cycle after the last byte. A new capture is possible at the first IDLE cycle.
- A valid that arrives while the block is busy is ignored. It remains pending upstream and is taken at the next IDLE cycle.
- The cycle after ack, valid may still read high for one cycle because the upstream ready clears registered. The block is then in SEND, so no double capture can occur.
- Byte selection is an index into a shift/mux of the capture register. Width rules: zero-extension only, no truncation.

Decomposition:
- Shared constants header holds:
  - the message ID value (MSG_ID),
  - the flag-bit positions (replaced = bit0, overrun = bit1),
  - the frame length macro.
- The packer consumes the existing received-number width macros for ADDR_WIDTH and DATA_WIDTH.
- Optional sub-module byte_serialiser: generic width-N parallel-load to byte valid/ready stream, MSB byte first. It is reusable by the other UART reply messages.

Test Plan (ADDR_WIDTH=8, DATA_WIDTH=16, 5-byte frames):
- Report {8'h2A, 16'hBEEF}, replaced=0, overrun=0, tx_ready always 1 -> ack one cycle at N+1; bytes 05, 00, 2A, BE, EF on consecutive cycles from N+2; busy low after.
- Report {8'h01, 16'h0000}, replaced=1, overrun=1 -> byte1 = 8'h03, payload 01 00 00.
- tx_ready toggling 1,0,0,1,... -> each byte held stable while stalled; exact 5-byte sequence; no duplicate or dropped bytes.
- Second valid asserted during SEND of the first frame -> no ack until IDLE; second frame follows with exactly one idle cycle between frames.
- Valid held high across the ack cycle and one cycle after (registered upstream clear) -> exactly one ack and one frame.
- n_reset low during byte 3 -> next cycle tx_valid=0, busy=0, ack=0; after release a fresh report produces a complete new frame starting at byte 05.

Source files
------------

// File: rtl/received_msg_packer_pkg.sv
// Shared constants for the received-number reply message: widths, message ID,
// flag-bit positions, frame length helper and the packer state encoding.
package received_msg_packer_pkg;

   localparam int unsigned RX_ADDR_WIDTH = 8;
   localparam int unsigned RX_DATA_WIDTH = 16;

   localparam logic [7:0] MSG_ID_RX_NUM = 8'h05;

   localparam int unsigned FLAG_REPLACED_BIT = 0;
   localparam int unsigned FLAG_OVERRUN_BIT  = 1;

   // ID byte + flags byte + zero-extended payload bytes
   function automatic int unsigned frame_bytes(input int unsigned payload_bits);
      return 2 + (payload_bits + 7) / 8;
   endfunction

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ACK  = 2'd1,
      ST_SEND = 2'd2
   } state_t;

endpackage

// File: rtl/received_msg_packer.sv
// Captures one received-number report, acknowledges it and streams it out as a
// framed byte message (ID, flags, payload MSB first) on a valid/ready byte bus.
module received_msg_packer
   import received_msg_packer_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = RX_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH = RX_DATA_WIDTH,
   parameter logic [7:0]  MSG_ID     = MSG_ID_RX_NUM
) (
   input  logic                           clk,
   input  logic                           n_reset,
   input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] mem_received_num,
   input  logic                           mem_received_replaced,
   input  logic                           mem_received_valid,
   input  logic                           mem_received_overrun,
   output logic                           mem_received_ack,
   output logic [7:0]                     tx_data,
   output logic                           tx_valid,
   input  logic                           tx_ready,
   output logic                           busy
);

   localparam int unsigned NUM_W         = ADDR_WIDTH + DATA_WIDTH;
   localparam int unsigned FRAME_BYTES   = frame_bytes(NUM_W);
   localparam int unsigned PAYLOAD_BYTES = FRAME_BYTES - 2;
   localparam int unsigned PAYLOAD_W     = 8 * PAYLOAD_BYTES;
   localparam int unsigned FRAME_W       = 8 * FRAME_BYTES;
   localparam int unsigned CTR_W         = $clog2(FRAME_BYTES);
   localparam logic [CTR_W-1:0] LAST_IDX = CTR_W'(FRAME_BYTES - 1);

   state_t             state;
   logic [CTR_W-1:0]   byte_ctr;
   logic [NUM_W-1:0]   cap_num;
   logic               cap_replaced;
   logic               cap_overrun;

   logic [7:0]         flags_c;
   logic [FRAME_W-1:0] frame_c;
   logic [FRAME_W-1:0] shifted_c;
   logic [CTR_W-1:0]   next_ctr_c;
   logic [CTR_W-1:0]   shift_idx_c;
   logic [7:0]         next_byte_c;

   // Whole frame as one vector; the next byte is picked by shifting it down.
   always_comb begin
      flags_c                    = '0;
      flags_c[FLAG_REPLACED_BIT] = cap_replaced;
      flags_c[FLAG_OVERRUN_BIT]  = cap_overrun;
      frame_c      = {MSG_ID, flags_c, PAYLOAD_W'(cap_num)};
      next_ctr_c   = byte_ctr + CTR_W'(1);
      shift_idx_c  = LAST_IDX - next_ctr_c;
      shifted_c    = frame_c >> {shift_idx_c, 3'b000};
      next_byte_c  = shifted_c[7:0];
   end

   // Capture / ack / send sequencer with registered outputs.
   always_ff @(posedge clk) begin
      if (!n_reset) begin
         state            <= ST_IDLE;
         byte_ctr         <= '0;
         cap_num          <= '0;
         cap_replaced     <= 1'b0;
         cap_overrun      <= 1'b0;
         mem_received_ack <= 1'b0;
         tx_data          <= '0;
         tx_valid         <= 1'b0;
         busy             <= 1'b0;
      end else begin
         mem_received_ack <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (mem_received_valid) begin
                  cap_num          <= mem_received_num;
                  cap_replaced     <= mem_received_replaced;
                  cap_overrun      <= mem_received_overrun;
                  mem_received_ack <= 1'b1;
                  busy             <= 1'b1;
                  state            <= ST_ACK;
               end
            end
            ST_ACK: begin
               tx_data  <= MSG_ID;
               tx_valid <= 1'b1;
               byte_ctr <= '0;
               state    <= ST_SEND;
            end
            ST_SEND: begin
               if (tx_valid && tx_ready) begin
                  if (byte_ctr == LAST_IDX) begin
                     tx_valid <= 1'b0;
                     busy     <= 1'b0;
                     state    <= ST_IDLE;
                  end else begin
                     byte_ctr <= next_ctr_c;
                     tx_data  <= next_byte_c;
                  end
               end
            end
            default: begin
               tx_valid <= 1'b0;
               busy     <= 1'b0;
               state    <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_received_msg_packer.sv
// Scoreboard bench: reports push their expected frame bytes into a queue, a
// negedge monitor pops and compares every transferred byte plus protocol rules.
module tb_received_msg_packer;

   logic        clk = 1'b0;
   logic        n_reset;
   logic [23:0] mem_received_num;
   logic        mem_received_replaced;
   logic        mem_received_valid;
   logic        mem_received_overrun;
   logic        mem_received_ack;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic        busy;

   always #5 clk = ~clk;

   received_msg_packer dut (
      .clk                   (clk),
      .n_reset               (n_reset),
      .mem_received_num      (mem_received_num),
      .mem_received_replaced (mem_received_replaced),
      .mem_received_valid    (mem_received_valid),
      .mem_received_overrun  (mem_received_overrun),
      .mem_received_ack      (mem_received_ack),
      .tx_data               (tx_data),
      .tx_valid              (tx_valid),
      .tx_ready              (tx_ready),
      .busy                  (busy)
   );

   int n_vec = 0;
   int n_err = 0;
   logic [7:0] exp_q[$];
   int reports = 0;
   int acks = 0;
   int ready_mode = 0;
   int pat = 0;

   function automatic void chk(input string name, input int act, input int expv);
      n_vec++;
      if (act != expv) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
      end
   endfunction

   // Reference frame: ID, flag byte, then the 24-bit report MSB first.
   function automatic void push_frame(input logic [23:0] num, input logic repl, input logic ovr);
      int unsigned v;
      v = num;
      exp_q.push_back(8'h05);
      exp_q.push_back(8'((ovr ? 2 : 0) + (repl ? 1 : 0)));
      for (int k = 2; k >= 0; k--)
         exp_q.push_back(8'((v >> (8 * k)) & 255));
   endfunction

   // Transmitter ready pattern generator
   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0: tx_ready = 1'b1;
         1: tx_ready = 1'($urandom_range(0, 1));
         default: begin
            tx_ready = (pat % 3 == 0);
            pat++;
         end
      endcase
   end

   // Monitor
   int cyc = 0;
   int last_xfer = 0;
   int frame_pos = 0;
   bit held = 0;
   bit prev_ack = 0;
   bit pend_last = 0;
   logic [7:0] held_data = 8'h00;

   always @(negedge clk) begin
      logic [7:0] b;
      cyc++;
      if (!n_reset) begin
         held = 0; prev_ack = 0; pend_last = 0; frame_pos = 0;
      end else begin
         if (prev_ack) chk("tx_valid_after_ack", int'(tx_valid), 1);
         if (mem_received_ack) begin
            acks++;
            chk("ack_single_cycle", int'(prev_ack), 0);
            chk("ack_not_while_sending", int'(tx_valid), 0);
            if (pend_last) begin
               chk("frame_gap", cyc - last_xfer, 2);
               pend_last = 0;
            end
         end
         if (tx_valid) chk("busy_while_valid", int'(busy), 1);
         if (held) begin
            chk("stall_valid_hold", int'(tx_valid), 1);
            chk("stall_data_hold", int'(tx_data), int'(held_data));
         end
         if (tx_valid && tx_ready) begin
            if (exp_q.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL unexpected_byte: got %0h expected none", tx_data);
            end else begin
               b = exp_q.pop_front();
               chk("tx_byte", int'(tx_data), int'(b));
            end
            frame_pos++;
            if (frame_pos == 5) begin
               frame_pos = 0;
               last_xfer = cyc;
               pend_last = mem_received_valid;
            end
         end
         held = tx_valid && !tx_ready;
         held_data = tx_data;
         prev_ack = mem_received_ack;
      end
   end

   task automatic send_report(input logic [23:0] num, input logic repl, input logic ovr,
                              input int extra, output int lat);
      bit got;
      @(posedge clk); #1;
      mem_received_num = num;
      mem_received_replaced = repl;
      mem_received_overrun = ovr;
      mem_received_valid = 1'b1;
      push_frame(num, repl, ovr);
      reports++;
      lat = 0; got = 0;
      while (!got && lat < 200) begin
         @(posedge clk); #1;
         lat++;
         if (mem_received_ack) got = 1;
      end
      if (!got) begin
         n_vec++; n_err++;
         $display("FAIL ack_timeout: got no ack expected ack within 200 cycles");
      end
      if (extra != 0) begin
         @(posedge clk); #1;
      end
      mem_received_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while ((exp_q.size() != 0 || busy) && t < 1000) begin
         @(posedge clk); #1;
         t++;
      end
      if (t >= 1000) begin
         n_vec++; n_err++;
         $display("FAIL idle_timeout: got busy expected idle");
      end
   endtask

   initial begin
      int lat;
      int t;
      logic [7:0] t1_bytes [5];
      t1_bytes = '{8'h05, 8'h00, 8'h2A, 8'hBE, 8'hEF};
      n_reset = 1'b0;
      mem_received_num = '0;
      mem_received_replaced = 1'b0;
      mem_received_valid = 1'b0;
      mem_received_overrun = 1'b0;
      tx_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_tx_valid", int'(tx_valid), 0);
      chk("reset_tx_data", int'(tx_data), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_ack", int'(mem_received_ack), 0);
      @(posedge clk); #1;
      n_reset = 1'b1;
      repeat (2) @(posedge clk);

      // Basic frame with latency and back-to-back byte checks
      ready_mode = 0;
      send_report(24'h2ABEEF, 1'b0, 1'b0, 0, lat);
      chk("ack_latency", lat, 1);
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t1_stream_valid", int'(tx_valid && tx_ready), 1);
         chk("t1_stream_byte", int'(tx_data), int'(t1_bytes[i]));
      end
      @(negedge clk);
      chk("t1_busy_after", int'(busy), 0);
      wait_idle();

      // Flags set, small payload
      send_report(24'h010000, 1'b1, 1'b1, 0, lat);
      wait_idle();

      // Stalling transmitter
      ready_mode = 2;
      send_report(24'hC3A512, 1'b0, 1'b1, 0, lat);
      wait_idle();
      ready_mode = 0;

      // Second report pending during SEND, valid held through registered clear
      send_report(24'h123456, 1'b1, 1'b0, 1, lat);
      send_report(24'h789ABC, 1'b0, 1'b0, 1, lat);
      wait_idle();

      // Reset in the middle of a frame
      send_report(24'hDEAD01, 1'b1, 1'b0, 0, lat);
      t = 0;
      while (exp_q.size() > 3 && t < 100) begin
         @(posedge clk); #1;
         t++;
      end
      n_reset = 1'b0;
      mem_received_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("midreset_tx_valid", int'(tx_valid), 0);
      chk("midreset_busy", int'(busy), 0);
      chk("midreset_ack", int'(mem_received_ack), 0);
      exp_q.delete();
      @(posedge clk); #1;
      n_reset = 1'b1;
      send_report(24'h55AA0F, 1'b0, 1'b1, 0, lat);
      chk("post_reset_ack_latency", lat, 1);
      wait_idle();

      // Randomized traffic
      for (int n = 0; n < 40; n++) begin
         ready_mode = int'($urandom_range(0, 2));
         send_report(24'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     int'($urandom_range(0, 1)), lat);
         repeat ($urandom_range(0, 3)) @(posedge clk);
      end
      ready_mode = 1;
      wait_idle();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("ack_count", acks, reports);
      chk("queue_drained", exp_q.size(), 0);
      chk("busy_end", int'(busy), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
